inst_fifo: RTL
==============

Name: inst_fifo

Overview:
- Decoupling buffer directly downstream of the fetch stage.
- Pairs each fetch request (aligned pc, intended pc, discard flag) with the 64-bit SRAM return one cycle later.
- Drops slot 0 on an unaligned entry and drops whole packets fetched under a taken branch or a flush.
- Queues up to 2 instructions per cycle and presents up to 2 per cycle to decode. Back-pressures fetch through a stall request.

Parameters:
- DEPTH, 16, instruction entries (power of 2, ≥8).
- FREE_TH, 4, minimum free entries required to keep fetch running (2 in flight + 2 requested).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush; empties buffer, kills in-flight packet.
- if_to_id_bus  in  `IF_TO_ID_WD  {discard, req_valid, pc_idef[31:0], pc_reg[31:0]} from fetch.
- inst_sram_rdata  in  64  fetch return; [31:0] at pc_reg, [63:32] at pc_reg+4.
- id_pop  in  2  entries consumed by decode this cycle (0..2, ≤ count).
- id_valid  out  2  bit k = head+k entry valid.
- id_pc0, id_pc1  out  32 each  pc of head, head+1.
- id_inst0, id_inst1  out  32 each  instruction of head, head+1.
- stallreq_fifo  out  1  to stall controller; 1 when free entries < FREE_TH.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0, async): rd/wr pointers=0, count=0, in-flight register cleared, id_valid=0, id_pc*/id_inst*=0, stallreq_fifo=0.
- Cycle t: if req_valid=1, latch {discard, pc_idef, pc_reg} into the in-flight register (pend_v=1). Otherwise pend_v=0.
- Cycle t+1: if pend_v=1 and discard=0 and flush=0, write entries:
  - pc_idef[2]=0: write 2 entries in order, {pc_reg, rdata[31:0]} then {pc_reg+4, rdata[63:32]}.
  - pc_idef[2]=1: write 1 entry, {pc_reg+4, rdata[63:32]}.
- pend_v=1 with discard=1: packet dropped, nothing written.
- flush=1 (sync priority over everything except reset):
  - next cycle count=0, pointers=0, pend_v=0.
  - Same-cycle write and pop ignored; a request presented in the flush cycle is still latched.
- Read: outputs are a combinational view of the head entries; id_valid = {count≥2, count≥1}. A pop of n advances rd pointer by n modulo DEPTH.
- Simultaneous write w and pop p: count_next = count + w − p. Pointers wrap modulo DEPTH, and a 2-entry write/read may straddle the wrap.
- stallreq_fifo = (DEPTH − count) < FREE_TH, combinational from registered count.
- Overflow (write with insufficient space) cannot occur when fetch honours stallreq. If it does, excess entries are dropped and count saturates at DEPTH.
- id_pop > count: only count entries are popped; count never underflows.

Optional Feature:
- INST_FIFO_BYPASS_EN defined:
  - When count=0 and a packet returns, its words drive id_valid/id_pc*/id_inst* in the same cycle.
  - Popped words are not written; unpopped words are written.
- Undefined: returning words are visible the cycle after the write (1-cycle fill latency).

Decomposition:
- Shared defines header (extends existing defines.vh):
  - `INST_FIFO_DEPTH
  - `INST_ENTRY_WD (64 = pc+inst)
  - `IF_TO_ID_WD field offsets (DISCARD_BIT, REQV_BIT)
  - `STALLBUS_WD already existing.
- Sub-module inst_fifo_ram: DEPTH×64 register array with 2 write ports (wptr, wptr+1) and 2 combinational read ports (rptr, rptr+1). Pointer and count logic stays in inst_fifo.

Test Plan:
- Aligned fetch pc_reg=0xbfc00000, pc_idef=0xbfc00000, rdata=0x22222222_11111111, id_pop=0 → next cycle count=2, id_pc0=0xbfc00000/id_inst0=0x11111111, id_pc1=0xbfc00004/id_inst1=0x22222222.
- Unaligned pc_reg=0xbfc00008, pc_idef=0xbfc0000c → single entry pc 0xbfc0000c, inst=rdata[63:32]; count +1.
- Request with discard=1 → returning packet dropped, count unchanged. Next request with discard=0 written normally.
- Fill with id_pop=0 and DEPTH=16 → stallreq_fifo rises when count=13. The in-flight packet is still accepted with no loss, and count never exceeds 16.
- Flush while count=7 and a packet is in flight → count=0 next cycle, in-flight packet not written, id_valid=00.
- Wrap: run wptr to 15, write 2 while popping 2 each cycle for 20 cycles → pc order strictly +4 sequential across the wrap. Assert rst mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/inst_fifo_pkg.sv
// Shared widths, fetch-bus layout and entry format for the fetch-to-decode instruction FIFO.
// Field offsets mirror the fetch bus: {discard, req_valid, pc_idef[31:0], pc_reg[31:0]}.
package inst_fifo_pkg;

  localparam int INST_FIFO_DEPTH = 16;
  localparam int INST_ENTRY_WD   = 64;
  localparam int IF_TO_ID_WD     = 66;
  localparam int DISCARD_BIT     = 65;
  localparam int REQV_BIT        = 64;
  localparam int STALLBUS_WD     = 6;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } inst_entry_t;

  typedef struct packed {
    logic        discard;
    logic        req_valid;
    logic [31:0] pc_idef;
    logic [31:0] pc_reg;
  } if_to_id_t;

  // Decode may ask for more than is available; only what is there gets consumed.
  function automatic logic [1:0] clamp_pop(input logic [1:0] req, input logic [1:0] avail);
    return (req > avail) ? avail : req;
  endfunction

endpackage

// File: rtl/inst_fifo_ram.sv
// Instruction FIFO storage: DEPTH x 64-bit entries, two write ports at waddr/waddr+1
// and two combinational read ports at raddr/raddr+1, both pairs wrapping modulo DEPTH.
module inst_fifo_ram
  import inst_fifo_pkg::*;
#(
  parameter int DEPTH = INST_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     we0,
  input  logic                     we1,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  inst_entry_t              wdata0,
  input  inst_entry_t              wdata1,
  output inst_entry_t              rdata0,
  output inst_entry_t              rdata1
);

  localparam int AW = $clog2(DEPTH);

  inst_entry_t   mem [DEPTH];
  logic [AW-1:0] waddr1;
  logic [AW-1:0] raddr1;

  assign waddr1 = waddr + AW'(1);
  assign raddr1 = raddr + AW'(1);

  // Storage needs no reset: the top masks every entry that is not counted as valid.
  always_ff @(posedge clk) begin
    if (we0) mem[waddr]  <= wdata0;
    if (we1) mem[waddr1] <= wdata1;
  end

  assign rdata0 = mem[raddr];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/inst_fifo.sv
// Fetch-to-decode instruction FIFO: pairs each fetch request with its SRAM return a cycle later.
// Build option INST_FIFO_BYPASS_EN: a returning packet is visible to decode in the same cycle when empty.
module inst_fifo
  import inst_fifo_pkg::*;
#(
  parameter int DEPTH   = INST_FIFO_DEPTH,
  parameter int FREE_TH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  input  logic [63:0]            inst_sram_rdata,
  input  logic [1:0]             id_pop,
  output logic [1:0]             id_valid,
  output logic [31:0]            id_pc0,
  output logic [31:0]            id_pc1,
  output logic [31:0]            id_inst0,
  output logic [31:0]            id_inst1,
  output logic                   stallreq_fifo,
  output logic [$clog2(DEPTH):0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if_to_id_t     req;
  logic          pend_v;
  logic          pend_discard;
  logic          pend_unaligned;
  logic [31:0]   pend_pc_reg;
  logic          unused_pc_idef_bits;

  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] count;

  inst_entry_t   ret_w0;
  inst_entry_t   ret_w1;
  logic [1:0]    ret_n;
  inst_entry_t   rd0;
  inst_entry_t   rd1;
  inst_entry_t   view0;
  inst_entry_t   view1;
  inst_entry_t   wr0;
  inst_entry_t   wr1;
  logic [1:0]    buf_avail;
  logic [1:0]    view_n;
  logic [1:0]    pop_n;
  logic [1:0]    buf_pop;
  logic [1:0]    wr_n;

  assign req = if_to_id_t'(if_to_id_bus);

  // Only the word-in-packet bit of the intended pc matters once the aligned pc is known.
  assign unused_pc_idef_bits = ^{req.pc_idef[31:3], req.pc_idef[1:0]};

  // In-flight register: what fetch asked for this cycle, matched with rdata next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_v         <= 1'b0;
      pend_discard   <= 1'b0;
      pend_unaligned <= 1'b0;
      pend_pc_reg    <= 32'd0;
    end else begin
      pend_v <= req.req_valid;
      if (req.req_valid) begin
        pend_discard   <= req.discard;
        pend_unaligned <= req.pc_idef[2];
        pend_pc_reg    <= req.pc_reg;
      end
    end
  end

  // Returning packet: an unaligned entry skips the low word, so slot 0 becomes the high word.
  always_comb begin
    ret_w1.pc   = pend_pc_reg + 32'd4;
    ret_w1.inst = inst_sram_rdata[63:32];
    ret_w0.pc   = pend_unaligned ? ret_w1.pc   : pend_pc_reg;
    ret_w0.inst = pend_unaligned ? ret_w1.inst : inst_sram_rdata[31:0];
    ret_n       = 2'd0;
    if (pend_v && !pend_discard && !flush)
      ret_n = pend_unaligned ? 2'd1 : 2'd2;
  end

  always_comb begin
    buf_avail = (count >= CW'(2)) ? 2'd2 : count[1:0];
    view_n    = buf_avail;
    view0     = rd0;
    view1     = rd1;
    wr0       = ret_w0;
    wr1       = ret_w1;
    pop_n     = clamp_pop(id_pop, buf_avail);
    buf_pop   = pop_n;
    wr_n      = ret_n;
`ifdef INST_FIFO_BYPASS_EN
    // Empty buffer: decode sees the returning words directly and only leftovers are stored.
    if (count == '0 && ret_n != 2'd0) begin
      view_n  = ret_n;
      view0   = ret_w0;
      view1   = ret_w1;
      pop_n   = clamp_pop(id_pop, ret_n);
      buf_pop = 2'd0;
      wr_n    = ret_n - pop_n;
      if (pop_n == 2'd1) wr0 = ret_w1;
    end
`endif
    // Words beyond the free space are dropped so the count saturates at DEPTH.
    if (int'(wr_n) > DEPTH - int'(count) + int'(buf_pop))
      wr_n = 2'(DEPTH - int'(count) + int'(buf_pop));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      rptr  <= rptr + AW'(buf_pop);
      wptr  <= wptr + AW'(wr_n);
      count <= count + CW'(wr_n) - CW'(buf_pop);
    end
  end

  inst_fifo_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we0    (wr_n != 2'd0),
    .we1    (wr_n == 2'd2),
    .waddr  (wptr),
    .raddr  (rptr),
    .wdata0 (wr0),
    .wdata1 (wr1),
    .rdata0 (rd0),
    .rdata1 (rd1)
  );

  assign id_valid      = {view_n == 2'd2, view_n != 2'd0};
  assign id_pc0        = id_valid[0] ? view0.pc   : 32'd0;
  assign id_inst0      = id_valid[0] ? view0.inst : 32'd0;
  assign id_pc1        = id_valid[1] ? view1.pc   : 32'd0;
  assign id_inst1      = id_valid[1] ? view1.inst : 32'd0;
  assign stallreq_fifo = (DEPTH - int'(count)) < FREE_TH;
  assign fifo_count    = count;

endmodule
